wb_pipe_stage: RTL
==================

# wb_pipe_stage

Parametrised MEM→WB pipeline boundary register with valid/ready handshake, a two-entry skid buffer, synchronous flush, register-zero write squashing and a head-entry forwarding tap. Sits between the memory stage and the register-file write port. Upstream can be back-pressured without a combinational ready path. The hazard unit reads the forwarding tap to bypass the pending write-back value.

## Interface
Parameters:
- DATA_W, 32, write-back data width (selected dmout/aluout/pc value)
- ADDR_W, 5, destination register index width
- CTRL_W, 5, opaque side-band bits carried with each beat (MemtoReg + Load)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat this cycle
- in_wen  in  1  beat writes the register file
- in_waddr  in  ADDR_W  destination register
- in_data  in  DATA_W  write-back value
- in_ctrl  in  CTRL_W  side-band
- out_valid  out  1  head entry valid
- out_ready  in  1  write-back consumes head this cycle
- out_wen / out_waddr / out_data / out_ctrl  out  1 / ADDR_W / DATA_W / CTRL_W  head entry fields
- flush  in  1  discard all held beats
- fwd_valid  out  1  head holds a live register write
- fwd_waddr  out  ADDR_W  forwarded destination
- fwd_data  out  DATA_W  forwarded value
- stall_cnt  out  CNT_W  saturating count of back-pressured cycles

## Operation
- Storage: head entry H (drives out_*) and skid entry S, each holding {valid, wen, waddr, data, ctrl}.
- in_ready = !S.valid, driven from a register only. There is no combinational path from out_ready to in_ready.
- Accept = in_valid && in_ready. Drain = out_valid && out_ready.
- Capture squash: an accepted beat with in_waddr == 0 is stored with wen = 0. data, waddr and ctrl are still stored unchanged.
- Next-state logic when flush = 0:
  - S empty, and H empty or draining: H loads the input if Accept; otherwise H.valid is cleared.
  - S empty, H valid and not draining: S loads the input if Accept.
  - S full and H draining: H is loaded from S, and S.valid is cleared.
  - S full and H not draining: hold.
- Ordering is strictly FIFO. A beat in S always leaves before any later beat.
- flush = 1 clears H.valid, S.valid, H.wen and S.wen at the edge.
  - flush has priority over a simultaneous Accept, which is dropped.
  - flush has priority over a simultaneous Drain. Drain still counts as consumed by downstream.
- Forwarding tap:
  - fwd_valid = H.valid && H.wen.
  - fwd_waddr = H.waddr and fwd_data = H.data, both purely combinational from H.
- stall_cnt increments every cycle with out_valid && !out_ready and saturates at all-ones. It is cleared only by reset; flush does not clear it.

## Timing
- Latency: a beat accepted at edge N appears on out_* after edge N and is consumable at edge N+1.
- Throughput: one beat per cycle while out_ready = 1.
- in_ready falls in the cycle after a beat enters S. It rises in the cycle after S drains into H.
- Reset values: out_valid = 0, out_wen = 0, out_waddr = 0, out_data = 0, out_ctrl = 0, in_ready = 1, fwd_valid = 0, fwd_waddr = 0, fwd_data = 0, stall_cnt = 0.
- Reset mid-operation: all held beats are lost immediately (asynchronous). Operation resumes on the first edge after rst_n rises.
- out_* fields are don't-care while out_valid = 0. Exception: out_wen must be 0 whenever out_valid = 0.

## Configuration
- WB_PIPE_SKID_EN defined: two-entry skid behaviour exactly as above.
- WB_PIPE_SKID_EN undefined: S is removed and the block is a single entry.
  - in_ready = !H.valid || out_ready, which is combinational from out_ready.
  - H loads the input whenever Accept, otherwise clears on Drain.
  - flush, squash, forwarding and stall_cnt behaviour are unchanged.

## Structure
- Shared package holds:
  - the entry struct typedef {valid, wen, waddr, data, ctrl}
  - the constant REG_ZERO = 0
  - default-width localparams DATA_W_DEF = 32, ADDR_W_DEF = 5
- One sub-module, wb_pipe_entry: a single reset-able entry register with load/clear enables. It is instantiated for H and, under WB_PIPE_SKID_EN, for S.

## Test plan
- Streaming:
  - Stimulus: out_ready = 1; beats waddr 1..8 with data 0x10..0x17, one per cycle.
  - Required: each appears one cycle later in order; in_ready stays 1; stall_cnt = 0.
- Back-pressure:
  - Stimulus: out_ready = 0 for 4 cycles while sending 3 beats (0xA, 0xB, 0xC).
  - Required: 0xA in H and 0xB in S; in_ready = 0 from the cycle after 0xB is accepted; 0xC is held upstream; stall_cnt = 4.
  - Then release: 0xA, 0xB, 0xC drain in order on consecutive cycles.
- Register-zero squash:
  - Stimulus: beat with wen = 1, waddr = 0, data = 0xDEAD.
  - Required: out_valid = 1, out_wen = 0, fwd_valid = 0, out_data = 0xDEAD.
- Flush:
  - Stimulus: with H and S both full, assert flush together with in_valid.
  - Required: next cycle out_valid = 0, in_ready = 1, and the flushed-cycle input does not appear; stall_cnt retains its value.
- Forwarding:
  - Stimulus: H holds wen = 1, waddr = 7, data = 0x1234 with out_ready = 0.
  - Required: fwd_valid = 1, fwd_waddr = 7, fwd_data = 0x1234 for every stalled cycle.
- Reset:
  - Stimulus: drop rst_n mid-stall with both entries full.
  - Required: all outputs take their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/wb_pipe_stage_pkg.sv
// Shared types and constants for the MEM->WB boundary stage.
// The entry struct is a default-width view of one held beat.
package wb_pipe_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CTRL_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  typedef struct packed {
    logic                  valid;
    logic                  wen;
    logic [ADDR_W_DEF-1:0] waddr;
    logic [DATA_W_DEF-1:0] data;
    logic [CTRL_W_DEF-1:0] ctrl;
  } wb_entry_t;

endpackage

// File: rtl/wb_pipe_entry.sv
// One held write-back beat with load and clear enables.
// clear drops valid and wen together so a dead entry never shows a write.
module wb_pipe_entry #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_waddr,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              q_valid,
  output logic              q_wen,
  output logic [ADDR_W-1:0] q_waddr,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_wen   <= 1'b0;
      q_waddr <= '0;
      q_data  <= '0;
      q_ctrl  <= '0;
    end else if (clear) begin
      q_valid <= 1'b0;
      q_wen   <= 1'b0;
    end else if (load) begin
      q_valid <= 1'b1;
      q_wen   <= d_wen;
      q_waddr <= d_waddr;
      q_data  <= d_data;
      q_ctrl  <= d_ctrl;
    end
  end

endmodule

// File: rtl/wb_pipe_stage.sv
// MEM->WB boundary register with flush, r0 write squash and a forwarding tap.
// Define WB_PIPE_SKID_EN for the two-entry skid buffer; otherwise single entry.
module wb_pipe_stage
  import wb_pipe_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wen,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wen,
  output logic [ADDR_W-1:0] out_waddr,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_waddr,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              h_valid, h_wen;
  logic [ADDR_W-1:0] h_waddr;
  logic [DATA_W-1:0] h_data;
  logic [CTRL_W-1:0] h_ctrl;
  logic              h_load, h_clr;
  logic              h_d_wen;
  logic [ADDR_W-1:0] h_d_waddr;
  logic [DATA_W-1:0] h_d_data;
  logic [CTRL_W-1:0] h_d_ctrl;
  logic              acc, drn, cap_wen;

  assign acc     = in_valid && in_ready;
  assign drn     = h_valid && out_ready;
  // Writes to r0 are carried as non-writing beats so the tap never bypasses them.
  assign cap_wen = in_wen && (in_waddr != ADDR_W'(REG_ZERO));

`ifdef WB_PIPE_SKID_EN
  logic              s_valid, s_wen;
  logic [ADDR_W-1:0] s_waddr;
  logic [DATA_W-1:0] s_data;
  logic [CTRL_W-1:0] s_ctrl;
  logic              s_load, s_clr, h_from_s;

  assign in_ready = !s_valid;

  always_comb begin
    h_load   = 1'b0;
    h_clr    = 1'b0;
    s_load   = 1'b0;
    s_clr    = 1'b0;
    h_from_s = 1'b0;
    if (flush) begin
      h_clr = 1'b1;
      s_clr = 1'b1;
    end else if (!s_valid) begin
      if (!h_valid || drn) begin
        if (acc) h_load = 1'b1;
        else     h_clr  = 1'b1;
      end else if (acc) begin
        s_load = 1'b1;
      end
    end else if (drn) begin
      h_load   = 1'b1;
      h_from_s = 1'b1;
      s_clr    = 1'b1;
    end
  end

  assign h_d_wen   = h_from_s ? s_wen   : cap_wen;
  assign h_d_waddr = h_from_s ? s_waddr : in_waddr;
  assign h_d_data  = h_from_s ? s_data  : in_data;
  assign h_d_ctrl  = h_from_s ? s_ctrl  : in_ctrl;

  wb_pipe_entry #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) u_skid (
    .clk(clk), .rst_n(rst_n), .load(s_load), .clear(s_clr),
    .d_wen(cap_wen), .d_waddr(in_waddr), .d_data(in_data), .d_ctrl(in_ctrl),
    .q_valid(s_valid), .q_wen(s_wen), .q_waddr(s_waddr), .q_data(s_data), .q_ctrl(s_ctrl)
  );
`else
  assign in_ready = !h_valid || out_ready;

  always_comb begin
    h_load = 1'b0;
    h_clr  = 1'b0;
    if (flush)    h_clr  = 1'b1;
    else if (acc) h_load = 1'b1;
    else if (drn) h_clr  = 1'b1;
  end

  assign h_d_wen   = cap_wen;
  assign h_d_waddr = in_waddr;
  assign h_d_data  = in_data;
  assign h_d_ctrl  = in_ctrl;
`endif

  wb_pipe_entry #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) u_head (
    .clk(clk), .rst_n(rst_n), .load(h_load), .clear(h_clr),
    .d_wen(h_d_wen), .d_waddr(h_d_waddr), .d_data(h_d_data), .d_ctrl(h_d_ctrl),
    .q_valid(h_valid), .q_wen(h_wen), .q_waddr(h_waddr), .q_data(h_data), .q_ctrl(h_ctrl)
  );

  assign out_valid = h_valid;
  assign out_wen   = h_wen;
  assign out_waddr = h_waddr;
  assign out_data  = h_data;
  assign out_ctrl  = h_ctrl;

  assign fwd_valid = h_valid && h_wen;
  assign fwd_waddr = h_waddr;
  assign fwd_data  = h_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (h_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
